// File: rtl/mem_io_bridge.sv
// CPU-side memory/IO bridge: decodes one CPU port onto a data RAM, two image RAMs,
// an LED register, a debounced push button and an image-write counter.
module mem_io_bridge #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] address_i,
  input  logic [31:0] data_i,
  input  logic        wren_i,
  output logic [31:0] data_o,
  input  logic        button_i,
  output logic [7:0]  LEDs_o,
  output logic        bus_err_o,
  output logic [11:0] dram_addr_o,
  output logic [31:0] dram_data_o,
  output logic        dram_we_o,
  input  logic [31:0] dram_q_i,
  output logic [15:0] imgin_addr_o,
  output logic [7:0]  imgin_data_o,
  output logic        imgin_we_o,
  input  logic [7:0]  imgin_q_i,
  output logic [15:0] imgout_addr_o,
  output logic [7:0]  imgout_data_o,
  output logic        imgout_we_o,
  input  logic [7:0]  imgout_q_i
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  typedef enum logic [2:0] {
    REG_UNMAPPED = 3'd0,
    REG_DRAM     = 3'd1,
    REG_LED      = 3'd2,
    REG_BTN      = 3'd3,
    REG_WCNT     = 3'd4,
    REG_IMGIN    = 3'd5,
    REG_IMGOUT   = 3'd6
  } region_t;

  region_t       w_region;
  region_t       r_region;
  logic [7:0]    r_leds;
  logic [31:0]   r_wcnt;
  logic          r_sync1;
  logic          r_sync2;
  logic          r_btn_level;
  logic          r_btn_flag;
  logic [CW-1:0] r_db_cnt;
  logic          r_bus_err;
  logic [31:0]   r_reg_rdata;
  logic          w_wr_ok;
  logic          w_btn_read;
  logic          w_db_diff;
  logic          w_db_done;
  logic          w_btn_rise;

  // Address decode
  always_comb begin
    w_region = REG_UNMAPPED;
    if (address_i[31:12] == 20'h00000) begin
      w_region = REG_DRAM;
    end else if (address_i == 32'h0000_2000) begin
      w_region = REG_LED;
    end else if (address_i == 32'h0000_2001) begin
      w_region = REG_BTN;
    end else if (address_i == 32'h0000_2002) begin
      w_region = REG_WCNT;
    end else if (address_i[31:16] == 16'h0001) begin
      w_region = REG_IMGIN;
    end else if (address_i[31:16] == 16'h0004) begin
      w_region = REG_IMGOUT;
    end else begin
      w_region = REG_UNMAPPED;
    end
  end

  assign w_wr_ok    = wren_i && !RST;
  assign w_btn_read = !wren_i && (w_region == REG_BTN);
  assign w_db_diff  = (r_sync2 != r_btn_level);
  assign w_db_done  = w_db_diff && (r_db_cnt == CW'(DEBOUNCE_CYCLES - 1));
  assign w_btn_rise = w_db_done && !r_btn_level;

  assign dram_addr_o   = address_i[11:0];
  assign dram_data_o   = data_i;
  assign dram_we_o     = w_wr_ok && (w_region == REG_DRAM);
  assign imgin_addr_o  = address_i[15:0];
  assign imgin_data_o  = data_i[7:0];
  assign imgin_we_o    = w_wr_ok && (w_region == REG_IMGIN);
  assign imgout_addr_o = address_i[15:0];
  assign imgout_data_o = data_i[7:0];
  assign imgout_we_o   = w_wr_ok && (w_region == REG_IMGOUT);
  assign LEDs_o        = r_leds;
  assign bus_err_o     = r_bus_err;

  // Region and register-read snapshot, taken before this cycle's register updates land
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_region    <= REG_UNMAPPED;
      r_reg_rdata <= 32'h0000_0000;
    end else begin
      r_region <= w_region;
      case (w_region)
        REG_LED:  r_reg_rdata <= {24'h00_0000, r_leds};
        REG_BTN:  r_reg_rdata <= {30'h0000_0000, r_btn_level, r_btn_flag};
        REG_WCNT: r_reg_rdata <= r_wcnt;
        default:  r_reg_rdata <= 32'h0000_0000;
      endcase
    end
  end

  // LED register, write counter and sticky bus error
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_leds    <= 8'h00;
      r_wcnt    <= 32'h0000_0000;
      r_bus_err <= 1'b0;
    end else begin
      if (wren_i && (w_region == REG_LED)) begin
        r_leds <= data_i[7:0];
      end
      if (wren_i && (w_region == REG_WCNT)) begin
        r_wcnt <= 32'h0000_0000;
      end else if (wren_i && (w_region == REG_IMGOUT)) begin
        r_wcnt <= r_wcnt + 32'h0000_0001;
      end
      if (w_region == REG_UNMAPPED) begin
        r_bus_err <= 1'b1;
      end
    end
  end

  // Button synchronizer, debouncer and rising-edge flag
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_sync1     <= 1'b0;
      r_sync2     <= 1'b0;
      r_btn_level <= 1'b0;
      r_btn_flag  <= 1'b0;
      r_db_cnt    <= '0;
    end else begin
      r_sync1 <= button_i;
      r_sync2 <= r_sync1;
      if (w_db_done) begin
        r_btn_level <= r_sync2;
        r_db_cnt    <= '0;
      end else if (w_db_diff) begin
        r_db_cnt <= r_db_cnt + CW'(1);
      end else begin
        r_db_cnt <= '0;
      end
      if (w_btn_rise) begin
        r_btn_flag <= 1'b1;
      end else if (w_btn_read) begin
        r_btn_flag <= 1'b0;
      end
    end
  end

  // Read-data mux on the registered region
  always_comb begin
    data_o = 32'h0000_0000;
    case (r_region)
      REG_DRAM:   data_o = dram_q_i;
      REG_IMGIN:  data_o = {24'h00_0000, imgin_q_i};
      REG_IMGOUT: data_o = {24'h00_0000, imgout_q_i};
      REG_LED:    data_o = r_reg_rdata;
      REG_BTN:    data_o = r_reg_rdata;
      REG_WCNT:   data_o = r_reg_rdata;
      default:    data_o = 32'h0000_0000;
    endcase
  end

endmodule

// File: tb/tb_mem_io_bridge.sv
// Self-checking bench for mem_io_bridge: behavioural RAMs plus a spec-level model.
module tb_mem_io_bridge;
  localparam int DB = 4;
  localparam int K_UNM = 0, K_DRAM = 1, K_LED = 2, K_BTN = 3, K_WCNT = 4, K_IMGIN = 5, K_IMGOUT = 6;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [31:0] address_i = 32'h0;
  logic [31:0] data_i = 32'h0;
  logic        wren_i = 1'b0;
  logic        button_i = 1'b0;
  logic [31:0] data_o;
  logic [7:0]  LEDs_o;
  logic        bus_err_o;
  logic [11:0] dram_addr_o;
  logic [31:0] dram_data_o;
  logic        dram_we_o;
  logic [31:0] dram_q_i;
  logic [15:0] imgin_addr_o;
  logic [7:0]  imgin_data_o;
  logic        imgin_we_o;
  logic [7:0]  imgin_q_i;
  logic [15:0] imgout_addr_o;
  logic [7:0]  imgout_data_o;
  logic        imgout_we_o;
  logic [7:0]  imgout_q_i;

  int errors = 0;
  int checks = 0;

  logic [31:0] ram_d [4096];
  logic [7:0]  ram_i [65536];
  logic [7:0]  ram_o [65536];
  logic [31:0] m_dram [4096];
  logic [7:0]  m_imgin [65536];
  logic [7:0]  m_imgout [65536];
  logic [7:0]  m_leds;
  logic [31:0] m_wcnt;
  logic        m_err;

  mem_io_bridge #(.DEBOUNCE_CYCLES(DB)) dut (
    .CLK(CLK), .RST(RST), .address_i(address_i), .data_i(data_i), .wren_i(wren_i),
    .data_o(data_o), .button_i(button_i), .LEDs_o(LEDs_o), .bus_err_o(bus_err_o),
    .dram_addr_o(dram_addr_o), .dram_data_o(dram_data_o), .dram_we_o(dram_we_o), .dram_q_i(dram_q_i),
    .imgin_addr_o(imgin_addr_o), .imgin_data_o(imgin_data_o), .imgin_we_o(imgin_we_o), .imgin_q_i(imgin_q_i),
    .imgout_addr_o(imgout_addr_o), .imgout_data_o(imgout_data_o), .imgout_we_o(imgout_we_o),
    .imgout_q_i(imgout_q_i)
  );

  always #5 CLK = ~CLK;

  // Synchronous RAMs with one-cycle read latency
  always @(posedge CLK) begin
    if (dram_we_o) ram_d[dram_addr_o] <= dram_data_o;
    if (imgin_we_o) ram_i[imgin_addr_o] <= imgin_data_o;
    if (imgout_we_o) ram_o[imgout_addr_o] <= imgout_data_o;
    dram_q_i   <= ram_d[dram_addr_o];
    imgin_q_i  <= ram_i[imgin_addr_o];
    imgout_q_i <= ram_o[imgout_addr_o];
  end

  function automatic int kind_of(input logic [31:0] a);
    if (a < 32'h1000) return K_DRAM;
    if (a == 32'h2000) return K_LED;
    if (a == 32'h2001) return K_BTN;
    if (a == 32'h2002) return K_WCNT;
    if (a >= 32'h10000 && a <= 32'h1FFFF) return K_IMGIN;
    if (a >= 32'h40000 && a <= 32'h4FFFF) return K_IMGOUT;
    return K_UNM;
  endfunction

  // One CPU cycle; write-enable outputs are checked against the decoded target every time
  task automatic access(input logic [31:0] a, input logic [31:0] d, input logic w, output logic [31:0] rd);
    int k;
    logic [2:0] exp_we;
    @(negedge CLK);
    address_i = a; data_i = d; wren_i = w;
    #1;
    k = kind_of(a);
    exp_we = {w && !RST && k == K_DRAM, w && !RST && k == K_IMGIN, w && !RST && k == K_IMGOUT};
    checks++;
    if ({dram_we_o, imgin_we_o, imgout_we_o} !== exp_we) begin
      errors++;
      $display("FAIL we_decode addr=%h: got %b want %b", a, {dram_we_o, imgin_we_o, imgout_we_o}, exp_we);
    end
    @(posedge CLK);
    #1;
    rd = data_o;
  endtask

  // Access through the model: reads of everything but BTN are compared, then LEDs and bus_err
  task automatic op(input logic [31:0] a, input logic [31:0] d, input logic w, input string name);
    int k;
    logic [31:0] exp_rd, rd;
    k = kind_of(a);
    case (k)
      K_DRAM:   exp_rd = m_dram[a[11:0]];
      K_IMGIN:  exp_rd = {24'h0, m_imgin[a[15:0]]};
      K_IMGOUT: exp_rd = {24'h0, m_imgout[a[15:0]]};
      K_LED:    exp_rd = {24'h0, m_leds};
      K_WCNT:   exp_rd = m_wcnt;
      default:  exp_rd = 32'h0;
    endcase
    access(a, d, w, rd);
    if (w) begin
      case (k)
        K_DRAM:   m_dram[a[11:0]] = d;
        K_IMGIN:  m_imgin[a[15:0]] = d[7:0];
        K_IMGOUT: begin m_imgout[a[15:0]] = d[7:0]; m_wcnt = m_wcnt + 32'h1; end
        K_LED:    m_leds = d[7:0];
        K_WCNT:   m_wcnt = 32'h0;
        default:  ;
      endcase
    end
    if (k == K_UNM) m_err = 1'b1;
    if (!w && k != K_BTN) begin
      checks++;
      if (rd !== exp_rd) begin
        errors++;
        $display("FAIL %s read addr=%h: got %h want %h", name, a, rd, exp_rd);
      end
    end
    checks++;
    if (LEDs_o !== m_leds || bus_err_o !== m_err) begin
      errors++;
      $display("FAIL %s state: leds=%h err=%b want leds=%h err=%b", name, LEDs_o, bus_err_o, m_leds, m_err);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) op(32'h0, 32'h0, 1'b0, "idle");
  endtask

  task automatic btn_read(input logic [31:0] exp, input string name);
    logic [31:0] rd;
    access(32'h2001, 32'h0, 1'b0, rd);
    checks++;
    if (rd !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, rd, exp);
    end
  endtask

  // Reset applied while an LED write is being presented
  task automatic apply_reset(input int n);
    @(negedge CLK);
    RST = 1'b1; address_i = 32'h2000; data_i = 32'hFF; wren_i = 1'b1;
    #1;
    checks++;
    if ({dram_we_o, imgin_we_o, imgout_we_o} !== 3'b000) begin
      errors++;
      $display("FAIL reset_we: got %b want 000", {dram_we_o, imgin_we_o, imgout_we_o});
    end
    repeat (n) @(posedge CLK);
    #1;
    checks++;
    if (LEDs_o !== 8'h00 || data_o !== 32'h0 || bus_err_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: leds=%h data=%h err=%b want 00/0/0", LEDs_o, data_o, bus_err_o);
    end
    m_leds = 8'h00; m_wcnt = 32'h0; m_err = 1'b0;
    RST = 1'b0; address_i = 32'h0; wren_i = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset(3);
  endtask

  task automatic test_dram();
    op(32'h10, 32'h1234_5678, 1'b1, "dram_wr");
    op(32'h10, 32'h0, 1'b0, "dram_rd");
    op(32'hFFF, 32'hCAFE_F00D, 1'b1, "dram_top_wr");
    op(32'hFFF, 32'h0, 1'b0, "dram_top_rd");
  endtask

  task automatic test_image();
    op(32'h40005, 32'h1AB, 1'b1, "imgout_wr");
    op(32'h40005, 32'h0, 1'b0, "imgout_rd");
    op(32'h10000, 32'hFF, 1'b1, "imgin_wr");
    op(32'h10000, 32'h0, 1'b0, "imgin_rd");
    op(32'h4FFFF, 32'h5C, 1'b1, "imgout_top_wr");
    op(32'h4FFFF, 32'h0, 1'b0, "imgout_top_rd");
    op(32'h2002, 32'h0, 1'b0, "wcnt_after_img");
  endtask

  task automatic test_regs();
    op(32'h2000, 32'hA5, 1'b1, "led_wr");
    op(32'h2000, 32'h0, 1'b0, "led_rd");
    op(32'h2002, 32'h1234, 1'b1, "wcnt_clr");
    for (int i = 0; i < 3; i++) op(32'h40000 + i, 32'h10 + i, 1'b1, "imgout_cnt");
    op(32'h2002, 32'h0, 1'b0, "wcnt_rd3");
    op(32'h2002, 32'hFFFF, 1'b1, "wcnt_clr2");
    op(32'h2002, 32'h0, 1'b0, "wcnt_rd0");
  endtask

  task automatic test_random();
    logic [31:0] a;
    for (int i = 0; i < 200; i++) begin
      case ($urandom_range(0, 4))
        0: a = {20'h0, 12'($urandom_range(0, 4095))};
        1: a = 32'h10000 | {16'h0, 16'($urandom_range(0, 255))};
        2: a = 32'h40000 | {16'h0, 16'($urandom_range(0, 255))};
        3: a = 32'h2000;
        default: a = ($urandom_range(0, 7) == 0) ? 32'h2002 : 32'h40000 | {16'h0, 16'($urandom_range(0, 255))};
      endcase
      op(a, $urandom, 1'($urandom_range(0, 1)), "random");
    end
  endtask

  task automatic test_button();
    button_i = 1'b1;
    idle(2);
    button_i = 1'b0;
    idle(8);
    btn_read(32'h0, "btn_glitch");
    button_i = 1'b1;
    idle(10);
    btn_read(32'h3, "btn_press");
    btn_read(32'h2, "btn_flag_clr");
    button_i = 1'b0;
    idle(10);
    btn_read(32'h0, "btn_release");
  endtask

  task automatic test_unmapped();
    op(32'h30000, 32'h0, 1'b0, "unm_rd");
    op(32'hFFFF_FFFF, 32'h77, 1'b1, "unm_wr");
    op(32'h1000, 32'h99, 1'b1, "unm_dram_edge");
    op(32'h10, 32'h0, 1'b0, "err_sticky");
    apply_reset(2);
  endtask

  task automatic test_reset_mid();
    op(32'h2000, 32'h3C, 1'b1, "led_pre_reset");
    button_i = 1'b1;
    idle(4);
    apply_reset(1);
    for (int e = 1; e <= DB + 3; e++) btn_read((e == DB + 3) ? 32'h3 : 32'h0, "btn_after_reset");
    button_i = 1'b0;
    idle(10);
    btn_read(32'h0, "btn_final");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish, want completion");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 4096; i++) begin ram_d[i] = 32'h0; m_dram[i] = 32'h0; end
    for (int i = 0; i < 65536; i++) begin
      ram_i[i] = 8'h0; ram_o[i] = 8'h0; m_imgin[i] = 8'h0; m_imgout[i] = 8'h0;
    end
    m_leds = 8'h0; m_wcnt = 32'h0; m_err = 1'b0;
    test_reset();
    test_dram();
    test_image();
    test_regs();
    test_random();
    test_button();
    test_unmapped();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mem_io_bridge.md
MEM_IO_BRIDGE -- requirements
Module: mem_io_bridge

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 16: the number of consecutive stable synchronized samples the button needs before it is accepted.
REQ-002 SHALL use one clock and a synchronous, active-high reset: CLK in 1, the single clock (all state updates on its rising edge); RST in 1, synchronous active-high reset.
REQ-003 SHALL have ports (name, direction, width, meaning):
- address_i in 32: CPU data word address.
- data_i in 32: CPU write data.
- wren_i in 1: CPU write enable.
- data_o out 32: read data to CPU.
- button_i in 1: asynchronous push button, active-high.
- LEDs_o out 8: LED register.
- bus_err_o out 1: sticky unmapped-access flag.
REQ-004 SHALL have data RAM ports: dram_addr_o out 12; dram_data_o out 32; dram_we_o out 1; dram_q_i in 32 (synchronous RAM, 1-cycle read).
REQ-005 SHALL have input-image RAM ports: imgin_addr_o out 16; imgin_data_o out 8; imgin_we_o out 1; imgin_q_i in 8 (1-cycle read).
REQ-006 SHALL have output-image RAM ports: imgout_addr_o out 16; imgout_data_o out 8; imgout_we_o out 1; imgout_q_i in 8 (1-cycle read).

Function
REQ-007 SHALL decode address_i combinationally into these regions:
- DRAM: 0x00000000-0x00000FFF.
- LED: 0x00002000.
- BTN: 0x00002001.
- WCNT: 0x00002002.
- IMGIN: 0x00010000-0x0001FFFF.
- IMGOUT: 0x00040000-0x0004FFFF.
- UNMAPPED: everything else.
REQ-008 SHALL drive the memory address outputs as address_i[11:0] or address_i[15:0] at all times, drive dram_data_o = data_i, and drive imgin_data_o = imgout_data_o = data_i[7:0].
REQ-009 SHALL assert a memory *_we_o only when wren_i=1 and address_i is in that memory's region; at most one *_we_o is high in any cycle.
REQ-010 SHALL register the decoded region of every access (read or write) on each clock; data_o is a combinational mux of the registered region, so read data is valid in the cycle after the address (latency 1).
REQ-011 SHALL return the following on data_o by registered region:
- DRAM: dram_q_i.
- IMGIN / IMGOUT: the 8-bit q zero-extended to 32 bits.
- LED: {24'b0, LEDs_o}.
- BTN: {30'b0, btn_level, btn_flag}.
- WCNT: wcnt.
- UNMAPPED: 0.
REQ-012 SHALL load LEDs_o <= data_i[7:0] on a write to LED.
REQ-013 SHALL pass button_i through a 2-flop synchronizer; the debounced btn_level changes only after the synchronized value differs from btn_level for DEBOUNCE_CYCLES consecutive cycles, and any intermediate match restarts the count.
REQ-014 SHALL set btn_flag on a 0->1 transition of btn_level and clear it on a read of BTN (address decoded in the cycle the read is issued); if a set and a clear coincide, set wins.
REQ-015 SHALL use a 32-bit counter wcnt that increments on each IMGOUT write and wraps from 0xFFFFFFFF to 0.
REQ-016 SHALL clear wcnt on any write to WCNT; the written data is ignored, and if the clear and an increment coincide (not possible in one cycle) clear has priority.
REQ-017 SHALL set bus_err_o on any read or write that decodes UNMAPPED; the flag stays set until reset, and UNMAPPED writes have no other effect.
REQ-018 SHALL give a read of any register in the same cycle as a write to it the old value.

Reset
REQ-019 SHALL, with RST=1 at a rising edge, clear LEDs_o, wcnt, btn_flag, btn_level, the synchronizer flops, the debounce counter, bus_err_o and the registered region (region resets to UNMAPPED, so data_o=0 in the cycle after reset).
REQ-020 SHALL hold all *_we_o low while RST=1, regardless of wren_i.
REQ-021 SHALL, when RST is asserted mid-debounce, discard the partial count; button_i high across reset yields btn_flag=1 only after DEBOUNCE_CYCLES+2 cycles after RST falls.

Verification
REQ-022 SHALL cover a DRAM write then read: write 0x12345678 @0x00000010, then read @0x00000010 -> dram_we_o pulses one cycle, and data_o=0x12345678 one cycle after the read address.
REQ-023 SHALL cover image writes and reads: write 0x1AB @0x00040005, then read @0x00040005 -> imgout_data_o=0xAB, data_o=0x000000AB, wcnt=1; a write 0xFF @0x00010000 asserts only imgin_we_o.
REQ-024 SHALL cover the LED and WCNT registers: write 0xA5 @0x2000 -> LEDs_o=0xA5; three IMGOUT writes, then read @0x2002 -> 3; write @0x2002, then read -> 0.
REQ-025 SHALL cover the button, with DEBOUNCE_CYCLES=4: 2-cycle glitch -> btn_level stays 0; hold 10 cycles -> read @0x2001 returns 0x3, the next read returns 0x2.
REQ-026 SHALL cover an unmapped access: read @0x00030000 -> data_o=0 and bus_err_o=1 thereafter; no *_we_o asserts; RST clears the flag.
REQ-027 SHALL cover reset mid-operation: RST during an LED write with wren_i=1 -> LEDs_o=0, all *_we_o=0.
